// File: rtl/accel_bus_pkg.sv
// ============================================================================
//  Module   : accel_bus_pkg
//  Brief    : Shared encodings for the accelerator register-bus responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_bus_pkg;

    localparam logic [1:0] c_RDWR_RD = 2'b10;
    localparam logic [1:0] c_RDWR_WR = 2'b01;

    localparam logic [2:0] c_REG_CTRL     = 3'd0;
    localparam logic [2:0] c_REG_STATUS   = 3'd1;
    localparam logic [2:0] c_REG_CFG_BASE = 3'd2;
    localparam int         c_NUM_CFG      = 6;

    localparam int c_CTRL_GO_BIT      = 0;
    localparam int c_CTRL_ERR_CLR_BIT = 15;

    localparam int c_STAT_BUSY_BIT = 0;
    localparam int c_STAT_DONE_BIT = 1;
    localparam int c_STAT_ERR_BIT  = 2;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_WAIT = 2'd1;
    localparam state_t c_ST_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/accel_regfile.sv
// ============================================================================
//  Module   : accel_regfile
//  Brief    : CTRL/STATUS/CFG register storage, read mux and sticky flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_regfile
    import accel_bus_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [2:0]                  wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [2:0]                  rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    input  logic                        bus_err,
    input  logic                        accel_busy,
    input  logic                        accel_done,
    output logic                        accel_go,
    output logic [c_NUM_CFG*DATA_W-1:0] cfg_out
);

    logic [DATA_W-1:0] r_cfg [c_NUM_CFG];
    logic              r_go;
    logic              r_done_sticky;
    logic              r_err_sticky;

    logic       w_ctrl_wr;
    logic       w_go_req;
    logic       w_go_ok;
    logic       w_go_err;
    logic       w_err_clr;
    logic [2:0] w_wr_idx;
    logic [2:0] w_rd_idx;

    assign w_ctrl_wr = wr_en && (wr_addr == c_REG_CTRL);
    assign w_go_req  = w_ctrl_wr && wr_data[c_CTRL_GO_BIT];
    assign w_go_ok   = w_go_req && !accel_busy;
    assign w_go_err  = w_go_req && accel_busy;
    assign w_err_clr = w_ctrl_wr && wr_data[c_CTRL_ERR_CLR_BIT];
    assign w_wr_idx  = wr_addr - c_REG_CFG_BASE;
    assign w_rd_idx  = rd_addr - c_REG_CFG_BASE;
    assign accel_go  = r_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_go          <= 1'b0;
            r_done_sticky <= 1'b0;
            r_err_sticky  <= 1'b0;
            for (int i = 0; i < c_NUM_CFG; i++) begin
                r_cfg[i] <= '0;
            end
        end else begin
            r_go <= w_go_ok;
            // An accepted go outranks a coincident accel_done; a new error outranks a clear.
            if (w_go_ok) begin
                r_done_sticky <= 1'b0;
            end else if (accel_done) begin
                r_done_sticky <= 1'b1;
            end
            if (bus_err || w_go_err) begin
                r_err_sticky <= 1'b1;
            end else if (w_err_clr) begin
                r_err_sticky <= 1'b0;
            end
            if (wr_en && (wr_addr >= c_REG_CFG_BASE)) begin
                r_cfg[w_wr_idx] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            c_REG_CTRL: rd_data = '0;
            c_REG_STATUS: begin
                rd_data[c_STAT_BUSY_BIT] = accel_busy;
                rd_data[c_STAT_DONE_BIT] = r_done_sticky;
                rd_data[c_STAT_ERR_BIT]  = r_err_sticky;
            end
            default: rd_data = r_cfg[w_rd_idx];
        endcase
    end

    generate
        for (genvar g = 0; g < c_NUM_CFG; g++) begin : g_cfg_out
            assign cfg_out[g*DATA_W +: DATA_W] = r_cfg[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/accel_bus_responder.sv
// ============================================================================
//  Module   : accel_bus_responder
//  Brief    : CPU register-bus responder: transaction FSM, wait states, tristate.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_bus_responder
    import accel_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bus_en,
    input  logic                bus_start,
    input  logic [1:0]          bus_rdwr,
    input  logic [2:0]          bus_regaddr,
    inout  wire  [DATA_W-1:0]   bus_data,
    output logic                bus_done,
    output logic                accel_go,
    input  logic                accel_busy,
    input  logic                accel_done,
    output logic [6*DATA_W-1:0] cfg_out
);

    localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_wait_cnt;
    logic [1:0]        r_rdwr;
    logic [2:0]        r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_idle;
    logic              w_accept;
    logic              w_enter_resp;
    logic              w_err;
    logic              w_wr_en;
    logic [1:0]        w_rdwr;
    logic [2:0]        w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_data;

    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_accept = w_idle && bus_en && bus_start;

    // With zero wait states RESP is entered on the accept edge, so fields come straight off the bus.
    assign w_rdwr  = w_idle ? bus_rdwr    : r_rdwr;
    assign w_addr  = w_idle ? bus_regaddr : r_addr;
    assign w_wdata = w_idle ? bus_data    : r_wdata;

    assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                          ((r_state == c_ST_WAIT) && bus_en && (r_wait_cnt == 4'd0));
    assign w_wr_en      = w_enter_resp && (w_rdwr == c_RDWR_WR);
    assign w_err        = (!w_idle && bus_en && bus_start) ||
                          (w_accept && (bus_rdwr != c_RDWR_RD) && (bus_rdwr != c_RDWR_WR));

    assign bus_done = (r_state == c_ST_RESP);
    assign bus_data = (bus_done && (r_rdwr == c_RDWR_RD)) ? r_rdata : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_rdwr     <= 2'b00;
            r_addr     <= 3'd0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_rdwr     <= bus_rdwr;
                        r_addr     <= bus_regaddr;
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_state    <= (WAIT_CYCLES == 0) ? c_ST_RESP : c_ST_WAIT;
                        if (bus_rdwr == c_RDWR_WR) begin
                            r_wdata <= bus_data;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (!bus_en) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_wait_cnt == 4'd0) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
            if (w_enter_resp) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    accel_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (w_wr_en),
        .wr_addr    (w_addr),
        .wr_data    (w_wdata),
        .rd_addr    (w_addr),
        .rd_data    (w_rd_data),
        .bus_err    (w_err),
        .accel_busy (accel_busy),
        .accel_done (accel_done),
        .accel_go   (accel_go),
        .cfg_out    (cfg_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_accel_bus_responder.sv
// ============================================================================
//  Module   : tb_accel_bus_responder
//  Brief    : Self-checking bench for accel_bus_responder (WAIT_CYCLES 1 and 3).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_accel_bus_responder;
    import accel_bus_pkg::*;

    // Buses are pulled up, so an undriven bus reads back as all ones.
    localparam logic [15:0] c_Z = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst, bus_en, bus_start, accel_busy, accel_done, cpu_drive, sel3;
    logic [1:0]  bus_rdwr;
    logic [2:0]  bus_regaddr;
    logic [15:0] cpu_data;
    tri1  [15:0] bus1, bus3;
    logic        done1, go1, done3, go3;
    logic [95:0] cfg1, cfg3;
    logic        obs_done, obs_go;
    logic [15:0] obs_bus;
    logic [95:0] obs_cfg;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign bus1     = cpu_drive ? cpu_data : 16'hzzzz;
    assign bus3     = cpu_drive ? cpu_data : 16'hzzzz;
    assign obs_done = sel3 ? done3 : done1;
    assign obs_go   = sel3 ? go3 : go1;
    assign obs_bus  = sel3 ? bus3 : bus1;
    assign obs_cfg  = sel3 ? cfg3 : cfg1;

    accel_bus_responder #(.WAIT_CYCLES(1), .DATA_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .bus_en(bus_en), .bus_start(bus_start), .bus_rdwr(bus_rdwr),
        .bus_regaddr(bus_regaddr), .bus_data(bus1), .bus_done(done1), .accel_go(go1),
        .accel_busy(accel_busy), .accel_done(accel_done), .cfg_out(cfg1));

    accel_bus_responder #(.WAIT_CYCLES(3), .DATA_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .bus_en(bus_en), .bus_start(bus_start), .bus_rdwr(bus_rdwr),
        .bus_regaddr(bus_regaddr), .bus_data(bus3), .bus_done(done3), .accel_go(go3),
        .accel_busy(accel_busy), .accel_done(accel_done), .cfg_out(cfg3));

    task automatic do_reset();
        rst = 1'b1; bus_en = 1'b0; bus_start = 1'b0; cpu_drive = 1'b0; accel_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete CPU transaction on the selected DUT, called and returning on a falling edge.
    task automatic txn(input logic [1:0] rw, input logic [2:0] addr, input logic [15:0] wd,
                       input bit pulse_done, output logic [15:0] rd, output int lat,
                       output bit go_seen, output bit stray);
        int wait_n;
        wait_n = sel3 ? 3 : 1;
        rd = c_Z; lat = 0; go_seen = 1'b0; stray = 1'b0;
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = rw; bus_regaddr = addr;
        cpu_data = wd; cpu_drive = (rw == c_RDWR_WR);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            bus_start  = 1'b0;
            accel_done = pulse_done && (i == wait_n);
            if (obs_done) begin
                lat = i; rd = obs_bus; go_seen = obs_go;
                break;
            end
            if (obs_go || (!cpu_drive && obs_bus !== c_Z)) stray = 1'b1;
        end
        accel_done = 1'b0;
        @(negedge clk);
        if (obs_done || obs_go || (!cpu_drive && obs_bus !== c_Z)) stray = 1'b1;
        bus_en = 1'b0; cpu_drive = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] rd; int lat; bit go, st;
        sel3 = 1'b0;
        do_reset();
        txn(c_RDWR_WR, 3'd7, 16'h1357, 1'b0, rd, lat, go, st);
        checks++; if (cfg1[95:80] !== 16'h1357) begin errors++; $display("FAIL pre_reset_cfg5: got %h expected %h", cfg1[95:80], 16'h1357); end
        do_reset();
        checks++; if (cfg1 !== 96'd0) begin errors++; $display("FAIL reset_cfg1: got %h expected 0", cfg1); end
        checks++; if ({done1, go1, done3, go3} !== 4'b0000) begin errors++; $display("FAIL reset_done_go: got %b expected 0000", {done1, go1, done3, go3}); end
        checks++; if (bus1 !== c_Z || bus3 !== c_Z) begin errors++; $display("FAIL reset_bus_z: got %h/%h expected %h", bus1, bus3, c_Z); end
    endtask

    task automatic test_write_read();
        logic [15:0] rd; int lat; bit go, st;
        sel3 = 1'b0;
        do_reset();
        txn(c_RDWR_WR, 3'd3, 16'hBEEF, 1'b0, rd, lat, go, st);
        checks++; if (lat !== 2 || st !== 1'b0) begin errors++; $display("FAIL wr_latency: got lat=%0d stray=%0d expected lat=2 stray=0", lat, st); end
        checks++; if (cfg1[31:16] !== 16'hBEEF) begin errors++; $display("FAIL wr_cfg1: got %h expected BEEF", cfg1[31:16]); end
        txn(c_RDWR_RD, 3'd3, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'hBEEF || lat !== 2 || st !== 1'b0) begin errors++; $display("FAIL rd_beef: got %h lat=%0d stray=%0d expected BEEF lat=2 stray=0", rd, lat, st); end
    endtask

    task automatic test_go();
        logic [15:0] rd; int lat; bit go, st;
        sel3 = 1'b0;
        do_reset();
        txn(c_RDWR_WR, c_REG_CTRL, 16'h0001, 1'b0, rd, lat, go, st);
        checks++; if (go !== 1'b1 || lat !== 2 || st !== 1'b0) begin errors++; $display("FAIL go_pulse: got go=%0d lat=%0d stray=%0d expected 1/2/0", go, lat, st); end
        accel_done = 1'b1; @(negedge clk); accel_done = 1'b0;
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL status_done: got %h expected 0002", rd); end
        txn(c_RDWR_RD, c_REG_CTRL, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL ctrl_reads_zero: got %h expected 0000", rd); end
        txn(c_RDWR_WR, c_REG_CTRL, 16'h0001, 1'b1, rd, lat, go, st);
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL go_clear_wins: got %h expected 0000", rd); end
    endtask

    task automatic test_go_busy();
        logic [15:0] rd; int lat; bit go, st;
        sel3 = 1'b0;
        do_reset();
        accel_busy = 1'b1;
        txn(c_RDWR_WR, c_REG_CTRL, 16'h0001, 1'b0, rd, lat, go, st);
        checks++; if (go !== 1'b0 || st !== 1'b0) begin errors++; $display("FAIL go_busy_suppressed: got go=%0d stray=%0d expected 0/0", go, st); end
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0005) begin errors++; $display("FAIL status_busy_err: got %h expected 0005", rd); end
        txn(c_RDWR_WR, c_REG_CTRL, 16'h8000, 1'b0, rd, lat, go, st);
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL err_clear: got %h expected 0001", rd); end
        txn(c_RDWR_WR, c_REG_CTRL, 16'h8001, 1'b0, rd, lat, go, st);
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0005) begin errors++; $display("FAIL err_set_wins: got %h expected 0005", rd); end
        accel_busy = 1'b0;
    endtask

    task automatic test_abort();
        logic [15:0] rd; int lat; bit go, st, saw_done, saw_drive;
        do_reset();
        saw_done = 1'b0; saw_drive = 1'b0;
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = c_RDWR_WR; bus_regaddr = 3'd4;
        cpu_data = 16'h1111; cpu_drive = 1'b1;
        @(negedge clk);
        bus_start = 1'b0; bus_en = 1'b0; cpu_drive = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done1 || done3) saw_done = 1'b1;
            if (bus1 !== c_Z || bus3 !== c_Z) saw_drive = 1'b1;
        end
        checks++; if (saw_done !== 1'b0 || saw_drive !== 1'b0) begin errors++; $display("FAIL abort_quiet: got done=%0d drive=%0d expected 0/0", saw_done, saw_drive); end
        checks++; if (cfg3[47:32] !== 16'h0000 || cfg1[47:32] !== 16'h0000) begin errors++; $display("FAIL abort_no_write: got %h/%h expected 0000", cfg1[47:32], cfg3[47:32]); end
        sel3 = 1'b1;
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0000 || lat !== 4 || st !== 1'b0) begin errors++; $display("FAIL abort_status_w3: got %h lat=%0d stray=%0d expected 0000 lat=4 stray=0", rd, lat, st); end
        sel3 = 1'b0;
    endtask

    task automatic test_illegal();
        logic [15:0] rd; int lat; bit go, st, d_resp, d_after;
        sel3 = 1'b0;
        do_reset();
        txn(2'b11, 3'd3, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (lat !== 2 || rd !== c_Z || st !== 1'b0) begin errors++; $display("FAIL illegal_done_nodrive: got lat=%0d bus=%h stray=%0d expected 2/%h/0", lat, rd, st, c_Z); end
        checks++; if (cfg1 !== 96'd0) begin errors++; $display("FAIL illegal_no_write: got %h expected 0", cfg1); end
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL illegal_err: got %h expected 0004", rd); end
        do_reset();
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = c_RDWR_WR; bus_regaddr = 3'd5;
        cpu_data = 16'h1234; cpu_drive = 1'b1;
        @(negedge clk);
        @(negedge clk);
        d_resp = done1; bus_start = 1'b0;
        @(negedge clk);
        d_after = done1; bus_en = 1'b0; cpu_drive = 1'b0;
        checks++; if ({d_resp, d_after} !== 2'b10) begin errors++; $display("FAIL extra_start_ignored: got %b expected 10", {d_resp, d_after}); end
        checks++; if (cfg1[63:48] !== 16'h1234) begin errors++; $display("FAIL extra_start_write: got %h expected 1234", cfg1[63:48]); end
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL extra_start_err: got %h expected 0004", rd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd; int lat, lat2; bit go, st, st2, saw_done;
        sel3 = 1'b0;
        do_reset();
        txn(c_RDWR_WR, 3'd5, 16'hA5A5, 1'b0, rd, lat, go, st);
        txn(c_RDWR_RD, 3'd5, 16'h0000, 1'b0, rd, lat2, go, st2);
        checks++; if (lat !== 2 || lat2 !== 2 || rd !== 16'hA5A5 || st2 !== 1'b0) begin errors++; $display("FAIL back_to_back: got lat=%0d/%0d rd=%h stray=%0d expected 2/2 A5A5 0", lat, lat2, rd, st2); end
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = c_RDWR_RD; bus_regaddr = 3'd5;
        @(negedge clk);
        bus_start = 1'b0;
        @(negedge clk);
        checks++; if (done1 !== 1'b1 || bus1 !== 16'hA5A5) begin errors++; $display("FAIL resp_cycle: got done=%0d bus=%h expected 1 A5A5", done1, bus1); end
        bus_start = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_start = 1'b0;
            if (done1 || bus1 !== c_Z) saw_done = 1'b1;
        end
        bus_en = 1'b0;
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL start_in_resp_ignored: got activity=%0d expected 0", saw_done); end
        txn(c_RDWR_RD, c_REG_STATUS, 16'h0000, 1'b0, rd, lat, go, st);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL start_in_resp_err: got %h expected 0004", rd); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd; int lat; bit go, st, saw_done;
        sel3 = 1'b1;
        do_reset();
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = c_RDWR_WR; bus_regaddr = 3'd2;
        cpu_data = 16'h00AA; cpu_drive = 1'b1;
        @(negedge clk);
        bus_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus_en = 1'b0; cpu_drive = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done3 || bus3 !== c_Z) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0 || cfg3 !== 96'd0) begin errors++; $display("FAIL rst_mid_wait: got activity=%0d cfg=%h expected 0/0", saw_done, cfg3); end
        txn(c_RDWR_WR, 3'd2, 16'h0055, 1'b0, rd, lat, go, st);
        checks++; if (lat !== 4 || cfg3[15:0] !== 16'h0055) begin errors++; $display("FAIL post_rst_txn: got lat=%0d cfg0=%h expected 4 0055", lat, cfg3[15:0]); end
        sel3 = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] m_cfg [6];
        bit          m_done, m_err, exp_go, is_rd;
        logic [15:0] exp_rd, rd, wd;
        logic [95:0] exp_cfg;
        logic [2:0]  addr;
        logic [1:0]  rw;
        int          op, lat;
        bit          go, st;
        sel3 = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) m_cfg[k] = 16'h0000;
        m_done = 1'b0; m_err = 1'b0;
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 6);
            accel_busy = ($urandom_range(0, 3) == 0);
            wd = 16'($urandom) & 16'h7FFF;
            exp_go = 1'b0; is_rd = 1'b0; exp_rd = c_Z;
            addr = 3'($urandom_range(2, 7)); rw = c_RDWR_WR;
            case (op)
                0: m_cfg[addr - 3'd2] = wd;
                1: begin rw = c_RDWR_RD; is_rd = 1'b1; exp_rd = m_cfg[addr - 3'd2]; end
                2: begin
                    addr = c_REG_CTRL;
                    wd[15] = 1'($urandom_range(0, 1));
                    wd[0]  = 1'($urandom_range(0, 1));
                    exp_go = wd[0] && !accel_busy;
                    if (wd[0] && accel_busy) m_err = 1'b1;
                    else if (wd[15]) m_err = 1'b0;
                    if (exp_go) m_done = 1'b0;
                end
                3: begin
                    addr = c_REG_STATUS; rw = c_RDWR_RD; is_rd = 1'b1;
                    exp_rd = {13'd0, m_err, m_done, accel_busy};
                end
                4: ;
                5: begin
                    if ($urandom_range(0, 1) == 1) addr = c_REG_STATUS;
                    else begin addr = c_REG_CTRL; rw = c_RDWR_RD; is_rd = 1'b1; exp_rd = 16'h0000; end
                end
                default: begin
                    rw = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                    addr = 3'($urandom_range(0, 7)); is_rd = 1'b1; m_err = 1'b1;
                end
            endcase
            if (op == 4) begin
                accel_done = 1'b1; @(negedge clk); accel_done = 1'b0;
                m_done = 1'b1;
            end else begin
                txn(rw, addr, wd, 1'b0, rd, lat, go, st);
                checks++; if (lat !== 2 || st !== 1'b0 || go !== exp_go) begin errors++; $display("FAIL rand_txn[%0d] op%0d: got lat=%0d stray=%0d go=%0d expected 2/0/%0d", n, op, lat, st, go, exp_go); end
                if (is_rd) begin
                    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rd[%0d] op%0d addr%0d: got %h expected %h", n, op, addr, rd, exp_rd); end
                end
            end
            for (int k = 0; k < 6; k++) exp_cfg[k*16 +: 16] = m_cfg[k];
            checks++; if (obs_cfg !== exp_cfg) begin errors++; $display("FAIL rand_cfg[%0d]: got %h expected %h", n, obs_cfg, exp_cfg); end
        end
        accel_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus_en = 1'b0; bus_start = 1'b0; bus_rdwr = 2'b00; bus_regaddr = 3'd0;
        accel_busy = 1'b0; accel_done = 1'b0; cpu_drive = 1'b0; cpu_data = 16'h0000; sel3 = 1'b0;
        test_reset();
        test_write_read();
        test_go();
        test_go_busy();
        test_abort();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/accel_bus_responder.md
Name: accel_bus_responder

Overview:
- Accelerator-side responder for the CPU accelerator register bus (bus_en / bus_start / bus_rdwr / bus_regaddr / bus_data / bus_done).
- Decodes CPU reads and writes into an 8-entry, 16-bit register file.
- Drives the shared tristate data bus on reads and returns a one-cycle bus_done.
- Turns CTRL writes into a go pulse for the accelerator core and exposes core status back to the CPU.

Parameters:
- WAIT_CYCLES, 1, wait states between the sampled start and bus_done (legal range 0..15).
- DATA_W, 16, bus data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- bus_en  in  1  CPU holds high for the whole transaction.
- bus_start  in  1  one-cycle transaction start, valid only with bus_en.
- bus_rdwr  in  2  2'b10 read (responder drives), 2'b01 write (CPU drives), 2'b00/2'b11 illegal.
- bus_regaddr  in  3  register index.
- bus_data  inout  DATA_W  shared data bus; hi-Z unless a read response is active.
- bus_done  out  1  one-cycle transaction completion.
- accel_go  out  1  one-cycle job start to the accelerator core.
- accel_busy  in  1  core busy level.
- accel_done  in  1  core job-complete pulse.
- cfg_out  out  6*DATA_W  CFG0..CFG5 concatenated, CFG0 in the LSBs.

Behaviour:
- Reset (sync, rst=1): state IDLE; bus_done=0; accel_go=0; bus_data=Z; all registers, done_sticky and err_sticky = 0. Reset mid-transaction aborts it with no write, no done and no drive.
- Register map:
  - 0 CTRL: write bit0=1 produces a go pulse (self-clearing); write bit15=1 clears err_sticky; reads as 0.
  - 1 STATUS (read-only): bit0=accel_busy (live), bit1=done_sticky, bit2=err_sticky, others 0. Writes are ignored.
  - 2..7 CFG0..CFG5: read/write, no side effects.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Start is accepted on an edge where bus_en & bus_start.
  - On accept, capture bus_rdwr and bus_regaddr. For writes, also capture bus_data on the same edge.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: counter runs for WAIT_CYCLES cycles, then the FSM enters RESP.
- Latency: start sampled on edge T gives bus_done high during cycle T+WAIT_CYCLES+1 (exactly one cycle).
- RESP:
  - bus_done=1 for one cycle.
  - Read: bus_data driven with the register value sampled on the edge entering RESP. Drive only during RESP; Z the next cycle.
  - Write: register updated on the edge entering RESP.
  - Next state is always IDLE.
- bus_en low in WAIT: abort to IDLE. No write, no done, no drive, err unchanged.
- bus_start while not IDLE: ignored; err_sticky set.
- Illegal rdwr (00/11) at start: transaction runs normally and bus_done is pulsed, but there is no write and no drive; err_sticky set.
- CTRL go while accel_busy=1: go suppressed; err_sticky set.
- Accepted go: accel_go=1 during RESP (same cycle as bus_done); done_sticky cleared.
- accel_done pulse sets done_sticky. If it coincides with an accepted go in the same cycle, the clear wins.
- Back-to-back transactions: the earliest next start is accepted in the cycle after RESP. A start during RESP itself is an error.
- Simultaneous error sources in one cycle set err_sticky once. A CTRL bit15 clear and a new error in the same cycle: set wins.

Decomposition:
- Package accel_bus_pkg holds:
  - rdwr encodings (RD=2'b10, WR=2'b01).
  - register index constants (CTRL=0, STATUS=1, CFG_BASE=2).
  - CTRL and STATUS bit positions.
  - FSM state enum.
- Sub-module accel_regfile holds:
  - register storage, read mux, CTRL side effects (go, err clear) and sticky bits.
- The top level keeps the FSM, wait counter and tristate driver.

Test Plan:
- WAIT_CYCLES=1, write 16'hBEEF to reg 3, then read reg 3 -> write bus_done 2 cycles after start; cfg_out[31:16]=16'hBEEF; read drives 16'hBEEF only in its done cycle; Z otherwise.
- Write CTRL=16'h0001 with accel_busy=0 -> accel_go and bus_done coincide for one cycle; then pulse accel_done; read STATUS -> 16'h0002.
- Write CTRL=16'h0001 with accel_busy=1 -> no accel_go; STATUS read -> 16'h0005. Write CTRL=16'h8000, then read STATUS -> 16'h0001.
- Start a write of 16'h1111 to reg 4 with WAIT_CYCLES=3, drop bus_en after 1 cycle -> no bus_done, reg 4 stays 0, bus_data Z throughout.
- bus_rdwr=2'b11 start -> bus_done pulses, bus_data stays Z, STATUS bit2=1. Extra bus_start during WAIT -> ignored, err set.
- Assert rst mid-WAIT of a write of 16'h00AA to reg 2 -> no done, cfg_out=0, and the next transaction completes normally.
